// File: rtl/mnist_pkg.sv
// Shared image geometry and streamer FSM encoding for the MNIST front end.
package mnist_pkg;

    localparam int IMG_WIDTH  = 28;
    localparam int IMG_HEIGHT = 28;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/pixel_stream_source_if.sv
// Bus between the frame streamer and its environment: buffer load port,
// frame control, and the pixel stream feeding conv1.
interface pixel_stream_source_if
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = mnist_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mnist_pkg::ADDR_WIDTH
);
    logic                         wr_en;
    logic        [ADDR_WIDTH-1:0] wr_addr;
    logic        [DATA_WIDTH-1:0] wr_data;
    logic                         start;
    logic                         pause;
    logic signed [DATA_WIDTH-1:0] pixel_out;
    logic                         valid_out;
    logic                         frame_last;
    logic                         busy;
    logic                         done;
    stream_state_t                fsm_state;

    // Stream handshake: valid_out qualifies pixel_out for exactly one cycle and
    // there is no ready; the consumer throttles by holding pause, which stops
    // new reads so valid_out drops from the following cycle onward.
    modport master (
        input  wr_en, wr_addr, wr_data, start, pause,
        output pixel_out, valid_out, frame_last, busy, done, fsm_state
    );

    modport slave (
        output wr_en, wr_addr, wr_data, start, pause,
        input  pixel_out, valid_out, frame_last, busy, done, fsm_state
    );

endinterface

// File: rtl/pixel_stream_source_ram.sv
// Frame buffer: one write port, one registered read port, storage not reset.
module pixel_frame_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 784
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // rd_data only moves on a read, so it doubles as the hold register
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// Streams one stored frame in row-major order to conv1, with pause stalls.
// Optional STREAMER_OFFSET_EN: output pixel_out as stored value minus 2^(DATA_WIDTH-1).
module pixel_stream_source
    import mnist_pkg::*;
#(
    parameter int IMG_WIDTH  = mnist_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = mnist_pkg::IMG_HEIGHT,
    parameter int DATA_WIDTH = mnist_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mnist_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_stream_source_if.master bus
);

    localparam int                    NUM_PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);

    stream_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_en;
    logic                  wr_ok;
    logic                  valid_q;
    logic                  last_q;
    logic                  done_q;
    logic                  have_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] pix;

    // Loads only while idle; a write alongside start still lands first.
    assign wr_ok = bus.wr_en && (state_q == IDLE) && (bus.wr_addr <= LAST_ADDR);

    pixel_frame_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (NUM_PIX)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = STREAM;
                    rd_addr_d = '0;
                end
            end
            STREAM: begin
                if (!bus.pause) begin
                    rd_en = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d   = IDLE;
                rd_addr_d = '0;
            end
            default: begin
                state_d   = IDLE;
                rd_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            have_data <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= rd_en;
            last_q    <= rd_en && (rd_addr_q == LAST_ADDR);
            done_q    <= (state_q == FLUSH);
            if (rd_en) begin
                have_data <= 1'b1;
            end
        end
    end

`ifdef STREAMER_OFFSET_EN
    assign pix = {~rd_data[DATA_WIDTH-1], rd_data[DATA_WIDTH-2:0]};
`else
    assign pix = rd_data;
`endif

    // have_data masks the unreset RAM output register until the first read
    assign bus.pixel_out  = have_data ? pix : '0;
    assign bus.valid_out  = valid_q;
    assign bus.frame_last = last_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: frame model with an expected-pixel queue plus
// directed frames (ramp, pause, intrusion, mid-frame reset, extremes, chained start).
module tb_pixel_stream_source;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int N  = 784;

`ifdef STREAMER_OFFSET_EN
    localparam logic [DW-1:0] L_00 = 8'h80;
    localparam logic [DW-1:0] L_02 = 8'h82;
    localparam logic [DW-1:0] L_05 = 8'h85;
    localparam logic [DW-1:0] L_0F = 8'h8F;
    localparam logic [DW-1:0] L_2C = 8'hAC;
    localparam logic [DW-1:0] L_64 = 8'hE4;
    localparam logic [DW-1:0] L_FF = 8'h7F;
`else
    localparam logic [DW-1:0] L_00 = 8'h00;
    localparam logic [DW-1:0] L_02 = 8'h02;
    localparam logic [DW-1:0] L_05 = 8'h05;
    localparam logic [DW-1:0] L_0F = 8'h0F;
    localparam logic [DW-1:0] L_2C = 8'h2C;
    localparam logic [DW-1:0] L_64 = 8'h64;
    localparam logic [DW-1:0] L_FF = 8'hFF;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_stream_source_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    pixel_stream_source #(
        .IMG_WIDTH  (28),
        .IMG_HEIGHT (28),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [DW-1:0] exp_pix(input int v);
`ifdef STREAMER_OFFSET_EN
        return DW'(v - (1 << (DW - 1)));
`else
        return DW'(v);
`endif
    endfunction

    // scoreboard / model
    logic [DW-1:0] mem_model [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_pix = '0;
    int to_issue = 0;
    bit model_busy = 0, exp_valid = 0, exp_done = 0, pending_done = 0, rst_seen = 0;

    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                to_issue = 0; model_busy = 0; exp_valid = 0;
                exp_done = 0; pending_done = 0; rst_seen = 1;
            end else begin
                rst_seen  = 0;
                exp_valid = (to_issue > 0) && !bus.pause;
                if (exp_valid) to_issue--;
                if (bus.wr_en && !model_busy && int'(bus.wr_addr) < N)
                    mem_model[bus.wr_addr] = bus.wr_data;
                if (bus.start && !model_busy) begin
                    model_busy = 1;
                    to_issue = N;
                    for (int i = 0; i < N; i++) exp_q.push_back(exp_pix(int'(mem_model[i])));
                end
                exp_done = pending_done;
                if (pending_done) model_busy = 0;
                pending_done = 0;
            end
            @(negedge clk);
            if (rst_seen) begin
                check("rst_valid_out", bus.valid_out, 0);
                check("rst_frame_last", bus.frame_last, 0);
                check("rst_done", bus.done, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_pixel_out", $unsigned(bus.pixel_out), 0);
                last_pix = '0;
            end else begin
                check("valid_out", bus.valid_out, exp_valid);
                if (exp_valid) begin
                    e = exp_q.pop_front();
                    check("pixel_out", $unsigned(bus.pixel_out), e);
                    check("frame_last", bus.frame_last, exp_q.size() == 0);
                    last_pix = e;
                    if (exp_q.size() == 0) pending_done = 1;
                end else begin
                    check("pixel_hold", $unsigned(bus.pixel_out), last_pix);
                    check("frame_last_idle", bus.frame_last, 0);
                end
                check("done", bus.done, exp_done);
                check("busy", bus.busy, model_busy);
            end
        end
    end

    // driver tasks
    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = DW'(i % 256);
        end
        @(negedge clk);
        bus.wr_en = 0;
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 0;
    endtask

    task automatic kick(input bit with_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.start = 1; bus.wr_en = with_wr; bus.wr_addr = a; bus.wr_data = d;
    endtask

    // Follows one frame from the start-sampling cycle until done (or until a
    // planted reset has settled), injecting pause / intrusion / reset by pixel count.
    task automatic stream_frame(input int pause_at, input int rst_at, input int intrude_at,
                                input int sel_idx, input bit chain,
                                output int nv, output int lat, output int gap,
                                output int last_idx, output int done_n,
                                output logic [DW-1:0] p_first, output logic [DW-1:0] p_sel);
        int cyc = 0, pause_left = 0, post = -1;
        bit paused = 0, intruded = 0, finished = 0;
        nv = 0; lat = -1; gap = 0; last_idx = -1; done_n = 0; p_first = '0; p_sel = '0;
        while (cyc < 3000 && !finished) begin
            @(negedge clk);
            cyc++;
            bus.start = 0;
            bus.wr_en = 0;
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) bus.pause = 0;
            end
            if (bus.valid_out) begin
                if (nv == 0) begin lat = cyc; p_first = bus.pixel_out; end
                if (nv == sel_idx) p_sel = bus.pixel_out;
                if (bus.frame_last) last_idx = nv;
                nv++;
            end else if (nv > 0 && last_idx < 0) begin
                gap++;
            end
            if (bus.done) begin
                done_n++;
                if (chain) bus.start = 1;
                finished = 1;
            end else if (post < 0) begin
                if (nv == pause_at && !paused) begin
                    paused = 1; bus.pause = 1; pause_left = 5;
                end
                if (nv == intrude_at && !intruded) begin
                    intruded = 1;
                    bus.start = 1; bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 8'hAA;
                end
                if (nv == rst_at) begin
                    rst_n = 0; post = 0;
                end
            end else begin
                if (post == 0) begin
                    check("rst_mid_valid_out", bus.valid_out, 0);
                    check("rst_mid_busy", bus.busy, 0);
                    rst_n = 1;
                end
                post++;
                if (post == 12) finished = 1;
            end
        end
        check("frame_timeout", finished, 1);
    endtask

    int nv, lat, gap, li, dn;
    logic [DW-1:0] p0, ps;

    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.pause = 0;
        for (int i = 0; i < N; i++) mem_model[i] = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        load_ramp();

        // ramp frame, no pause
        kick(0, '0, '0);
        stream_frame(-1, -1, -1, 783, 0, nv, lat, gap, li, dn, p0, ps);
        check("ramp_count", nv, 784);
        check("ramp_latency", lat, 2);
        check("ramp_gap", gap, 0);
        check("ramp_last_idx", li, 783);
        check("ramp_done", dn, 1);
        check("ramp_pix0", p0, L_00);
        check("ramp_pix783", ps, L_0F);

        // pause 5 cycles at pixel 100
        kick(0, '0, '0);
        stream_frame(100, -1, -1, 100, 0, nv, lat, gap, li, dn, p0, ps);
        check("pause_count", nv, 784);
        check("pause_gap", gap, 5);
        check("pause_pix100", ps, L_64);
        check("pause_done", dn, 1);

        // start + write during STREAM are ignored
        kick(0, '0, '0);
        stream_frame(-1, -1, 2, 5, 0, nv, lat, gap, li, dn, p0, ps);
        check("intrude_count", nv, 784);
        check("intrude_done", dn, 1);
        check("intrude_pix5", ps, L_05);
        kick(0, '0, '0);
        stream_frame(-1, -1, -1, 5, 0, nv, lat, gap, li, dn, p0, ps);
        check("after_intrude_pix5", ps, L_05);
        check("after_intrude_count", nv, 784);

        // reset mid-frame at pixel 300, then replay
        kick(0, '0, '0);
        stream_frame(-1, 300, -1, 0, 0, nv, lat, gap, li, dn, p0, ps);
        check("rst_count", nv, 300);
        check("rst_no_done", dn, 0);
        kick(0, '0, '0);
        stream_frame(-1, -1, -1, 300, 0, nv, lat, gap, li, dn, p0, ps);
        check("replay_count", nv, 784);
        check("replay_pix0", p0, L_00);
        check("replay_pix300", ps, L_2C);

        // extremes, start with a same-cycle write, chained into the next frame
        write_px(1, 8'h00);
        kick(1, 0, 8'hFF);
        stream_frame(-1, -1, -1, 1, 1, nv, lat, gap, li, dn, p0, ps);
        check("ext_pix0", p0, L_FF);
        check("ext_pix1", ps, L_00);
        check("ext_done", dn, 1);
        stream_frame(-1, -1, -1, 2, 0, nv, lat, gap, li, dn, p0, ps);
        check("chain_latency", lat, 2);
        check("chain_count", nv, 784);
        check("chain_pix0", p0, L_FF);
        check("chain_pix2", ps, L_02);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 28, meaning pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 28, meaning rows per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning pixel width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, meaning frame buffer address width (>= clog2(IMG_WIDTH*IMG_HEIGHT)).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1, meaning frame buffer write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_WIDTH, meaning write address (row*IMG_WIDTH+col).
REQ-009 SHALL have port wr_data, input, DATA_WIDTH, meaning unsigned pixel to store.
REQ-010 SHALL have port start, input, 1, meaning begin streaming one frame.
REQ-011 SHALL have port pause, input, 1, meaning stall the stream.
REQ-012 SHALL have port pixel_out, output, DATA_WIDTH signed, meaning streamed pixel, the conv1 pixel_in feed.
REQ-013 SHALL have port valid_out, output, 1, meaning pixel_out qualifier, the conv1 valid_in feed.
REQ-014 SHALL have port frame_last, output, 1, meaning high with the final pixel of a frame.
REQ-015 SHALL have port busy, output, 1, meaning FSM not IDLE.
REQ-016 SHALL have port done, output, 1, meaning one-cycle frame-complete pulse.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, FLUSH; IDLE->STREAM on start; STREAM->FLUSH after last read issued; FLUSH->IDLE after last pixel output.
REQ-018 SHALL store wr_data at wr_addr on wr_en in IDLE only; writes in STREAM/FLUSH SHALL be dropped; wr_addr >= IMG_WIDTH*IMG_HEIGHT SHALL be dropped.
REQ-019 SHALL ignore start when not IDLE; start with wr_en in same IDLE cycle SHALL perform both, the write landing before pixel at that address is read.
REQ-020 SHALL read frame buffer with one-cycle synchronous latency, addresses 0..IMG_WIDTH*IMG_HEIGHT-1 in increasing (row-major) order, each exactly once.
REQ-021 SHALL assert valid_out for pixel 0 in the second cycle after the cycle in which start is sampled high; with pause low, pixels SHALL be emitted on consecutive cycles (784 valid cycles back-to-back at default).
REQ-022 SHALL, while pause=1, hold the read address and deassert valid_out from the next cycle; on pause release SHALL resume with the next unsent pixel, no loss or duplication.
REQ-023 SHALL hold pixel_out at its last value when valid_out=0.
REQ-024 SHALL assert frame_last together with valid_out of address IMG_WIDTH*IMG_HEIGHT-1 only.
REQ-025 SHALL pulse done for exactly one cycle, in the cycle after frame_last, coincident with return to IDLE (busy=0).
REQ-026 SHALL allow start in the cycle done is high, beginning the next frame with no extra gap.

Reset
REQ-027 SHALL, with rst_n=0 at a clock edge, force state IDLE, read address 0, valid_out=0, frame_last=0, done=0, busy=0, pixel_out=0.
REQ-028 SHALL, on reset mid-frame, abandon the frame with no further valid_out and no done; frame buffer contents SHALL NOT be cleared.

Configuration
REQ-029 SHALL, with macro STREAMER_OFFSET_EN defined, output pixel_out = stored value minus 2^(DATA_WIDTH-1) (MSB inverted), mapping 0..255 to -128..127.
REQ-030 SHALL, without STREAMER_OFFSET_EN, output the stored bits unchanged.

Structure
REQ-031 SHALL take IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH, NUM_PIXELS, ADDR_WIDTH defaults and FSM state encodings from shared package mnist_pkg.
REQ-032 SHALL place the buffer in sub-module pixel_frame_ram (1 write port, 1 synchronous read port, no reset on storage).

Verification
REQ-033 SHALL cover: load ramp mem[i]=i%256, start, no pause -> 784 consecutive valid_out, pixel i = i%256, frame_last on 784th, done 1 cycle later.
REQ-034 SHALL cover: pause high for 5 cycles at pixel 100 -> valid_out low 5 cycles, next valid pixel is 100, total 784 pixels.
REQ-035 SHALL cover: start and wr_en asserted during STREAM -> start ignored, buffer unchanged in next frame.
REQ-036 SHALL cover: rst_n low at pixel 300 -> next cycle valid_out=0, busy=0, no done; restart replays original data from pixel 0.
REQ-037 SHALL cover: STREAMER_OFFSET_EN defined, mem=0x00 and 0xFF -> pixel_out -128 and 127; undefined -> 0x00 and 0xFF.
REQ-038 SHALL cover: start asserted in done cycle -> second frame's pixel 0 valid two cycles later, no lost pixels.
